// File: rtl/frame_bank_writer.sv
// frame_bank_writer: streams one 1bpp frame into the selected ping-pong bank, pulses bank_full, then waits for a swap.
module frame_bank_writer #(
    parameter int FRAME_W         = 40,
    parameter int FRAME_H         = 32,
    parameter int BYTES_PER_FRAME = FRAME_W * FRAME_H / 8,
    parameter int ADDR_W          = 8
) (
    input  logic              CLK_40,
    input  logic              reset,
    input  logic              write_bank1,
    input  logic              write_bank2,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en_b1,
    output logic              wr_en_b2,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              bank_full,
    output logic [15:0]       frame_count,
    output logic              overrun,
    output logic              sel_error
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BYTES_PER_FRAME - 1);
    state_t            state, state_n;
    logic [1:0]        sel, cur_bank;
    logic [ADDR_W-1:0] addr;
    logic              hs, load, swap;
    assign sel = (write_bank1 && !write_bank2) ? 2'd1 : (write_bank2 && !write_bank1) ? 2'd2 : 2'd0;
    assign hs  = in_valid && in_ready;
    always_comb begin
        state_n  = state;
        load     = 1'b0;
        swap     = 1'b0;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                load    = sel != 2'd0;
                state_n = load ? FILL : IDLE;
            end
            FILL: begin
                swap     = sel != cur_bank;
                in_ready = !swap;
                load     = swap && sel != 2'd0;
                state_n  = swap ? (load ? FILL : IDLE) : (in_valid && addr == LAST) ? DONE : FILL;
            end
            DONE: begin
                load    = sel != 2'd0 && sel != cur_bank;
                state_n = load ? FILL : (sel == 2'd0) ? IDLE : DONE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK_40) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    // Write strobe, bank_full and frame_count all land one cycle after the accepting handshake
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            cur_bank    <= 2'd0;
            addr        <= '0;
            wr_en_b1    <= 1'b0;
            wr_en_b2    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 8'd0;
            bank_full   <= 1'b0;
            frame_count <= 16'd0;
            overrun     <= 1'b0;
            sel_error   <= 1'b0;
        end else begin
            wr_en_b1  <= hs && cur_bank == 2'd1;
            wr_en_b2  <= hs && cur_bank == 2'd2;
            bank_full <= hs && addr == LAST;
            overrun   <= overrun || swap;
            sel_error <= sel_error || (write_bank1 && write_bank2);
            if (hs) begin
                wr_addr <= addr;
                wr_data <= in_data;
                addr    <= addr + 1'b1;
            end
            if (hs && addr == LAST) frame_count <= frame_count + 16'd1;
            if (load) begin
                cur_bank <= sel;
                addr     <= '0;
            end
        end
    end
endmodule
